data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised word-addressed data memory for the datapath, with variable width and depth, byte-enable writes and a registered read with valid strobe. A multi-cycle initialisation FSM clears the array, so it maps to RAM primitives without a one-cycle clear. It uses a request/ready handshake and sits between the load/store unit and the storage array.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 16, word address width.
DEPTH, 65536, number of implemented words; must be at most 2**ADDR_W.
INIT_VAL, 0, word value written to every location during clear.

Ports:
clk  in  1  clock; all state is updated on the rising edge.
rst  in  1  asynchronous, active-low reset.
clr  in  1  request a full-array clear; sampled only in IDLE.
req  in  1  access request; accepted when req=1 and ready=1.
we  in  1  1 = write, 0 = read; qualified by req.
be  in  DATA_W/8  byte enables for writes; bit i enables byte i (bits 8i+7:8i).
addr  in  ADDR_W  word address.
wdata  in  DATA_W  write data.
ready  out  1  controller can accept a request this cycle.
rvalid  out  1  one-cycle strobe: rdata is valid.
rdata  out  DATA_W  read data; held until the next rvalid.
err  out  1  one-cycle strobe: accepted access addressed a word at or above DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to INIT and the clear counter goes to 0.
  - ready=0, rvalid=0, err=0, rdata=0.
  - Array contents are not touched by the reset itself.
- States:
  - INIT: writes INIT_VAL to word clr_cnt every cycle and increments clr_cnt. ready=0.
    - When clr_cnt=DEPTH-1 is written, go to IDLE on the next edge.
    - A full clear takes exactly DEPTH cycles after reset release.
  - IDLE: ready=1.
    - If clr=1 and req=0: go to INIT, clr_cnt=0, ready drops next cycle.
    - If clr=1 and req=1 in the same cycle: the access is accepted first; clr is ignored that cycle.
- Write (req & we & ready):
  - Only bytes with be[i]=1 are updated, at the edge of acceptance.
  - be=0 is a legal no-op and still counts as accepted.
  - No rvalid is produced.
- Read (req & ~we & ready):
  - rdata and rvalid=1 are driven from registers in the cycle after acceptance; latency is 1.
  - Back-to-back reads give rvalid on consecutive cycles.
- Read after write: a read of an address issued the cycle after a write to it returns the new data.
- Out of range (addr >= DEPTH):
  - Write: dropped.
  - Read: rdata=0 and rvalid=1.
  - Both: err=1 for one cycle, aligned with where rvalid would be.
- Requests while ready=0 are ignored, with no side effects.
- Reset mid-clear or mid-read: the pending rvalid is cancelled and the clear restarts from word 0.
- clr_cnt is ADDR_W+1 bits wide so that DEPTH=2**ADDR_W terminates correctly.

Optional Feature:
DMEM_PARITY_EN:
- Defined:
  - Each byte stores an extra even-parity bit, computed on write; INIT stores parity of INIT_VAL.
  - A read whose stored parity mismatches sets err=1 alongside rvalid; rdata still returns the stored data.
  - The array width becomes DATA_W + DATA_W/8.
- Not defined: no parity storage; err reports out-of-range accesses only.

Decomposition:
- Package dmem_pkg holds:
  - enum state_t {INIT, IDLE}
  - function byte_merge(old, new, be)
  - function parity_byte(data) (used only under DMEM_PARITY_EN)
- One sub-module, dmem_array: a single-port synchronous RAM with per-byte write enables and registered read, parametrised by width and depth.
- The controller holds the FSM, the clear counter, range checking and the rvalid/err pipeline.

Test Plan:
- Release reset with DEPTH=16 → ready=0 for exactly 16 cycles, then 1; reads of words 0..15 all return 0 with rvalid one cycle after each request.
- Write addr=3, wdata=32'hDEADBEEF, be=4'b1111, then write addr=3, wdata=32'h000000AA, be=4'b0001, then read addr=3 → rdata=32'hDEADBEAA.
- Issue back-to-back reads of addr 1, 2, 3 after writing 11, 22, 33 → rvalid high three consecutive cycles with rdata 11, 22, 33.
- With DEPTH=16, ADDR_W=5: write addr=20, then read addr=20 → err pulses once per access, write dropped, read returns rdata=0; word 4 is unchanged.
- Assert clr in IDLE, then rst low during cycle 5 of the clear → ready=0 and rvalid=0 immediately; after rst release ready rises after 16 cycles and all words equal INIT_VAL.
- With DMEM_PARITY_EN defined, force-flip one stored bit of word 7 via backdoor, then read addr=7 → rvalid=1 and err=1 in the same cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
//   state_t     : controller FSM states (INIT = array clear, IDLE = serving accesses)
//   byte_merge  : one byte lane of a masked write (keep old byte unless enabled)
//   parity_byte : even-parity bit of one byte (used by the DMEM_PARITY_EN build)
package dmem_pkg;

  typedef enum logic {INIT, IDLE} state_t;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

  // Even parity: the stored bit makes the 9-bit lane have an even count of ones.
  function automatic logic parity_byte(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
// The word is DATA_W data bits plus PAR_W side bits (one per byte lane, or none);
// side bit i is written together with byte lane i.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-low reset, clears only the read register
//   en    : access enable
//   we    : 1 = write, 0 = read (qualified by en)
//   be    : per-byte write enables
//   addr  : word address
//   wdata : write word (side bits in the top PAR_W bits)
//   rdata : registered read word, held between reads
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned ADDR_W = 16,
  parameter  int unsigned DEPTH  = 65536,
  parameter  int unsigned PAR_W  = 0,
  localparam int unsigned NB     = DATA_W / 8,
  localparam int unsigned SW     = DATA_W + PAR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [SW-1:0]     wdata,
  output logic [SW-1:0]     rdata
);

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] cur;
  logic [SW-1:0] merged;

  assign cur = mem[addr];

  always_comb begin
    merged = cur;
    for (int unsigned i = 0; i < NB; i++) begin
      merged[i*8 +: 8] = byte_merge(cur[i*8 +: 8], wdata[i*8 +: 8], be[i]);
    end
    for (int unsigned i = 0; i < PAR_W; i++) begin
      merged[DATA_W+i] = be[i] ? wdata[DATA_W+i] : cur[DATA_W+i];
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              rdata <= '0;
    else if (en && !we)    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory controller: multi-cycle clear FSM, request/ready
// handshake, byte-enable writes, 1-cycle registered reads with rvalid strobe,
// and out-of-range detection.
// Optional build macro DMEM_PARITY_EN: stores one even-parity bit per byte and
// flags a parity mismatch on read through err.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset (array contents untouched)
//   clr    : start a full-array clear, sampled in IDLE with no request
//   req    : access request, accepted when ready=1
//   we     : 1 = write, 0 = read
//   be     : byte enables for writes
//   addr   : word address
//   wdata  : write data
//   ready  : controller accepts a request this cycle
//   rvalid : one-cycle strobe, rdata valid
//   rdata  : read data, held until the next rvalid
//   err    : one-cycle strobe, out-of-range access (or parity error)
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 65536,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int unsigned NB = DATA_W / 8;
`ifdef DMEM_PARITY_EN
  localparam int unsigned PAR_W = NB;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned SW = DATA_W + PAR_W;

  // One extra bit so DEPTH = 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W:0]     clr_cnt;
  logic                rvalid_q;
  logic                err_q;
  logic                oor_q;     // last accepted read was out of range
  logic                oor;
  logic                accept;
  logic                par_err;

  logic                m_en;
  logic                m_we;
  logic [NB-1:0]       m_be;
  logic [ADDR_W-1:0]   m_addr;
  logic [SW-1:0]       m_wdata;
  logic [SW-1:0]       m_rdata;
  logic [SW-1:0]       wr_word;
  logic [SW-1:0]       init_word;

  assign oor    = ({1'b0, addr} >= DEPTH_X);
  assign accept = req & ready;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] wpar;
  logic [NB-1:0] ipar;
  logic [NB-1:0] rpar;

  always_comb begin
    wpar = '0;
    ipar = '0;
    rpar = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wpar[i] = parity_byte(wdata[i*8 +: 8]);
      ipar[i] = parity_byte(INIT_VAL[i*8 +: 8]);
      rpar[i] = parity_byte(m_rdata[i*8 +: 8]);
    end
  end

  assign wr_word   = {wpar, wdata};
  assign init_word = {ipar, INIT_VAL};
  assign par_err   = rvalid_q & ~oor_q & (rpar != m_rdata[SW-1:DATA_W]);
`else
  assign wr_word   = wdata;
  assign init_word = INIT_VAL;
  assign par_err   = 1'b0;
`endif

  // Clear writes own the array port in INIT; in IDLE only in-range accepted
  // accesses reach it, so dropped writes and out-of-range reads never touch it.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = addr;
    m_wdata = wr_word;
    if (state == INIT) begin
      m_en    = 1'b1;
      m_we    = 1'b1;
      m_be    = '1;
      m_addr  = clr_cnt[ADDR_W-1:0];
      m_wdata = init_word;
    end else if (accept && !oor) begin
      m_en = 1'b1;
      m_we = we;
      m_be = be;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PAR_W  (PAR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (m_en),
    .we    (m_we),
    .be    (m_be),
    .addr  (m_addr),
    .wdata (m_wdata),
    .rdata (m_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      clr_cnt  <= '0;
      ready    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state)
        INIT: begin
          if (clr_cnt == LAST) begin
            state   <= IDLE;
            ready   <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          // A request in the same cycle as clr wins; clr is ignored.
          if (req) begin
            rvalid_q <= ~we;
            err_q    <= oor;
            if (!we) oor_q <= oor;
          end else if (clr) begin
            state   <= INIT;
            ready   <= 1'b0;
            clr_cnt <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Out-of-range reads leave the array register untouched and are masked here.
  assign rdata  = oor_q ? '0 : m_rdata[DATA_W-1:0];
  assign rvalid = rvalid_q;
  assign err    = err_q | par_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t rq[$];   // expected read responses
  exp_t wq[$];   // expected write-error strobes
  exp_t e;

  data_memory_ctrl #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .DEPTH    (16),
    .INIT_VAL (32'h0)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .req    (req),
    .we     (we),
    .be     (be),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: pops expected responses when the DUT presents rvalid or err.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rvalid === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid: got rdata=%h err=%b, want no rvalid", rdata, err);
        end else begin
          e = rq.pop_front();
          if (rdata !== e.data || err !== e.err || cyc != e.cyc) begin
            failures++;
            $display("FAIL %s: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                     e.name, rdata, err, cyc, e.data, e.err, e.cyc);
          end
        end
      end else if (err === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_err: got err=1 without rvalid, want err=0");
        end else begin
          e = wq.pop_front();
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL %s: got err at cyc=%0d, want cyc=%0d", e.name, cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Issue one access (inputs change 1 time unit after an edge); push the expected
  // response with the cycle count at which the monitor must see it.
  task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e,
                       input string name);
    check({name, "_ready"}, {31'b0, ready}, 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    if (!w) rq.push_back('{exp_d, exp_e, cyc, name});
    else if (exp_e) wq.push_back('{32'h0, 1'b1, cyc, name});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises; a clear of 16 words must take exactly 16.
  task automatic measure_clear(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready === 1'b1) break;
    end
    check(name, 32'(n), 32'd16);
  endtask

  initial begin
    #2;
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_rvalid", {31'b0, rvalid}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    #21 rst = 1'b1;
    check("init_ready_low", {31'b0, ready}, 32'd0);
    measure_clear("init_clear_cycles");

    for (int i = 0; i < 16; i++) issue(1'b0, 5'(i), 32'h0, 4'h0, 32'h0, 1'b0, "init_read");
    idle(2);

    // byte-enable merge and be=0 no-op
    issue(1'b1, 5'd3, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, "wr_full");
    issue(1'b1, 5'd3, 32'h000000AA, 4'b0001, 32'h0, 1'b0, "wr_byte0");
    issue(1'b0, 5'd3, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "rd_merge");
    issue(1'b1, 5'd3, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, "wr_be0");
    issue(1'b0, 5'd3, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "rd_after_be0");
    issue(1'b1, 5'd2, 32'h11223344, 4'b1010, 32'h0, 1'b0, "wr_be1010");
    issue(1'b0, 5'd2, 32'h0, 4'h0, 32'h11003300, 1'b0, "rd_be1010");
    idle(2);

    // back-to-back reads, and read the cycle after a write
    issue(1'b1, 5'd1, 32'd11, 4'hF, 32'h0, 1'b0, "wr_11");
    issue(1'b1, 5'd2, 32'd22, 4'hF, 32'h0, 1'b0, "wr_22");
    issue(1'b1, 5'd3, 32'd33, 4'hF, 32'h0, 1'b0, "wr_33");
    issue(1'b0, 5'd1, 32'h0, 4'h0, 32'd11, 1'b0, "b2b_rd1");
    issue(1'b0, 5'd2, 32'h0, 4'h0, 32'd22, 1'b0, "b2b_rd2");
    issue(1'b0, 5'd3, 32'h0, 4'h0, 32'd33, 1'b0, "b2b_rd3");
    issue(1'b1, 5'd6, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "wr_raw");
    issue(1'b0, 5'd6, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "rd_raw");
    idle(2);

    // out of range: addr 20 would alias word 4 if not dropped
    issue(1'b1, 5'd4, 32'h44444444, 4'hF, 32'h0, 1'b0, "wr_4");
    issue(1'b1, 5'd20, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "oor_wr");
    issue(1'b0, 5'd20, 32'h0, 4'h0, 32'h0, 1'b1, "oor_rd");
    issue(1'b0, 5'd4, 32'h0, 4'h0, 32'h44444444, 1'b0, "rd_4_unchanged");
    issue(1'b0, 5'd15, 32'h0, 4'h0, 32'h0, 1'b0, "rd_last_word");
    idle(2);

    // clr with req in the same cycle: access wins, clr ignored
    clr = 1'b1;
    issue(1'b1, 5'd5, 32'h55, 4'hF, 32'h0, 1'b0, "clr_req_wr");
    clr = 1'b0;
    check("clr_req_ready", {31'b0, ready}, 32'd1);
    issue(1'b0, 5'd5, 32'h0, 4'h0, 32'h55, 1'b0, "clr_req_rd");
    idle(3);

    // clear, then reset during its fifth cycle
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_ready_drop", {31'b0, ready}, 32'd0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midclr_rst_ready", {31'b0, ready}, 32'd0);
    check("midclr_rst_rvalid", {31'b0, rvalid}, 32'd0);
    // requests while not ready must have no effect
    req = 1'b1; we = 1'b1; addr = 5'd2; wdata = 32'hFFFFFFFF; be = 4'hF;
    @(negedge clk) rst = 1'b1;
    measure_clear("reclear_cycles");
    req = 1'b0; we = 1'b0;
    for (int i = 0; i < 16; i++) issue(1'b0, 5'(i), 32'h0, 4'h0, 32'h0, 1'b0, "reclear_read");
    idle(2);

`ifdef DMEM_PARITY_EN
    issue(1'b1, 5'd7, 32'h12345678, 4'hF, 32'h0, 1'b0, "par_wr");
    issue(1'b0, 5'd7, 32'h0, 4'h0, 32'h12345678, 1'b0, "par_rd_ok");
    idle(1);
    u_dut.u_array.mem[7][0] = ~u_dut.u_array.mem[7][0];
    issue(1'b0, 5'd7, 32'h0, 4'h0, 32'h12345679, 1'b1, "par_rd_bad");
    idle(2);
`endif

    idle(3);
    check("rd_queue_drained", 32'(rq.size()), 32'd0);
    check("err_queue_drained", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
